nibble_serial_addsub_seq: RTL

//  Multi-cycle sequencer that performs WIDTH-bit add/subtract by driving one shared 4-bit add/sub slice.

---
 rtl/nibble_serial_addsub_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub_seq.sv
// nibble_serial_addsub_seq: WIDTH-bit add/sub on one shared 4-bit slice,
// LSB nibble first, NBEATS = WIDTH/4 beats per operation.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, a, b, sub   request side
//   out_valid/out_ready, sum, cout result side
//   busy                           high in RUN or DONE
//   ovf                            signed overflow (only with ADDSUB_OVF_EN)
// Optional feature macro: ADDSUB_OVF_EN
module nibble_serial_addsub_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBEATS = WIDTH / 4;
  localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  bx_q, bx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
`ifdef ADDSUB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [IDXW+1:0]   base;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        slice;

  always_comb begin
    base  = {idx_q, 2'b00};
    a_nib = a_q[base +: 4];
    b_nib = bx_q[base +: 4];
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bx_d    = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice[4];
`ifdef ADDSUB_OVF_EN
          // carry into the MSB is recovered from its sum bit
          ovf_d   = (a_nib[3] ^ b_nib[3] ^ slice[3]) ^ slice[4];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
    a_q  <= a_d;
    bx_q <= bx_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
